// File: rtl/id_stage_piped_pkg.sv
// rtl/id_stage_piped_pkg.sv - decode constants and control bundle for the ID stage
package id_stage_piped_pkg;

  localparam logic [3:0] EXE_NONE = 4'b0000;
  localparam logic [3:0] EXE_MOV  = 4'b0001;
  localparam logic [3:0] EXE_ADD  = 4'b0010;
  localparam logic [3:0] EXE_ADC  = 4'b0011;
  localparam logic [3:0] EXE_SUB  = 4'b0100;
  localparam logic [3:0] EXE_SBC  = 4'b0101;
  localparam logic [3:0] EXE_AND  = 4'b0110;
  localparam logic [3:0] EXE_ORR  = 4'b0111;
  localparam logic [3:0] EXE_EOR  = 4'b1000;
  localparam logic [3:0] EXE_MVN  = 4'b1001;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  typedef struct packed {
    logic       s;
    logic       b;
    logic       mem_r;
    logic       mem_w;
    logic       wb_en;
    logic [3:0] exe_cmd;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/id_stage_piped_regfile.sv
// rtl/id_stage_piped_regfile.sv - 2-read/1-write register file with writeback bypass
module id_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int BYPASS_EN  = 1,
  localparam int REG_W     = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_en,
  input  logic [REG_W-1:0]      wb_dest,
  input  logic [DATA_WIDTH-1:0] wb_value,
  input  logic [3:0]            ra1,
  input  logic [3:0]            ra2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // A writeback coinciding with reset is dropped along with everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_en && (int'(wb_dest) < NUM_REGS)) begin
      regs[wb_dest] <= wb_value;
    end
  end

  always_comb begin
    rd1 = '0;
    if (int'(ra1) < NUM_REGS) begin
      if ((BYPASS_EN != 0) && wb_en && (int'(wb_dest) == int'(ra1))) rd1 = wb_value;
      else rd1 = regs[ra1[REG_W-1:0]];
    end
  end

  always_comb begin
    rd2 = '0;
    if (int'(ra2) < NUM_REGS) begin
      if ((BYPASS_EN != 0) && wb_en && (int'(wb_dest) == int'(ra2))) rd2 = wb_value;
      else rd2 = regs[ra2[REG_W-1:0]];
    end
  end

endmodule

// File: rtl/id_stage_piped.sv
// rtl/id_stage_piped.sv - ARM decode stage with built-in ID/EXE pipeline register
module id_stage_piped
  import id_stage_piped_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int BYPASS_EN  = 1,
  localparam int REG_W     = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic [31:0]           instr_in,
  input  logic                  valid_in,
  input  logic                  hazard,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  z,
  input  logic                  c,
  input  logic                  v,
  input  logic                  n,
  input  logic                  wb_en,
  input  logic [REG_W-1:0]      wb_dest,
  input  logic [DATA_WIDTH-1:0] wb_value,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  valid_out,
  output logic                  s_out,
  output logic                  b_out,
  output logic                  mem_r_en_out,
  output logic                  mem_w_en_out,
  output logic                  wb_en_out,
  output logic [3:0]            exe_cmd_out,
  output logic [DATA_WIDTH-1:0] val_rn_out,
  output logic [DATA_WIDTH-1:0] val_rm_out,
  output logic                  imm_out,
  output logic [11:0]           shift_op_out,
  output logic [23:0]           simm24_out,
  output logic [REG_W-1:0]      dest_out,
  output logic [REG_W-1:0]      src1_out,
  output logic [REG_W-1:0]      src2_out,
  output logic                  two_src,
  output logic [REG_W-1:0]      hz_src1,
  output logic [REG_W-1:0]      hz_src2
);

  logic [3:0] cond, opcode, rn, rd, rm, src2_sel;
  logic [1:0] mode;
  logic       s_bit, imm_bit, is_store, cond_pass, bubble;
  logic [DATA_WIDTH-1:0] rn_val, rm_val;
  ctrl_t      ctrl, ctrl_q;

  assign cond     = instr_in[31:28];
  assign mode     = instr_in[27:26];
  assign imm_bit  = instr_in[25];
  assign opcode   = instr_in[24:21];
  assign s_bit    = instr_in[20];
  assign rn       = instr_in[19:16];
  assign rd       = instr_in[15:12];
  assign rm       = instr_in[3:0];
  assign is_store = (mode == MODE_MEM) && !s_bit;
  // STR needs Rd as its store data, so it takes over the second read port.
  assign src2_sel = is_store ? rd : rm;

  assign two_src  = ~imm_bit | is_store;
  assign hz_src1  = rn[REG_W-1:0];
  assign hz_src2  = src2_sel[REG_W-1:0];

  id_regfile #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .BYPASS_EN (BYPASS_EN)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .wb_en   (wb_en),
    .wb_dest (wb_dest),
    .wb_value(wb_value),
    .ra1     (rn),
    .ra2     (src2_sel),
    .rd1     (rn_val),
    .rd2     (rm_val)
  );

  always_comb begin
    ctrl = CTRL_NONE;
    case (mode)
      MODE_DP: begin
        ctrl.wb_en = 1'b1;
        case (opcode)
          OP_MOV:  ctrl.exe_cmd = EXE_MOV;
          OP_MVN:  ctrl.exe_cmd = EXE_MVN;
          OP_ADD:  ctrl.exe_cmd = EXE_ADD;
          OP_ADC:  ctrl.exe_cmd = EXE_ADC;
          OP_SUB:  ctrl.exe_cmd = EXE_SUB;
          OP_SBC:  ctrl.exe_cmd = EXE_SBC;
          OP_AND:  ctrl.exe_cmd = EXE_AND;
          OP_ORR:  ctrl.exe_cmd = EXE_ORR;
          OP_EOR:  ctrl.exe_cmd = EXE_EOR;
          OP_CMP:  begin ctrl.exe_cmd = EXE_SUB; ctrl.wb_en = 1'b0; end
          OP_TST:  begin ctrl.exe_cmd = EXE_AND; ctrl.wb_en = 1'b0; end
          default: ctrl.wb_en = 1'b0;
        endcase
        if (ctrl.exe_cmd != EXE_NONE) ctrl.s = s_bit;
      end
      MODE_MEM: begin
        ctrl.exe_cmd = EXE_ADD;
        ctrl.mem_r   = s_bit;
        ctrl.wb_en   = s_bit;
        ctrl.mem_w   = !s_bit;
      end
      MODE_BR: ctrl.b = 1'b1;
      default: ctrl = CTRL_NONE;
    endcase
  end

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = ~z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = ~c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = ~n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = ~v;
      COND_HI: cond_pass = c & ~z;
      COND_LS: cond_pass = ~c | z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = ~z & (n == v);
      COND_LE: cond_pass = z | (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign bubble = hazard | ~cond_pass | ~valid_in;

  // Flush clears the data fields too, so it shares the reset path and overrides freeze.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pc_out       <= '0;
      valid_out    <= 1'b0;
      ctrl_q       <= CTRL_NONE;
      val_rn_out   <= '0;
      val_rm_out   <= '0;
      imm_out      <= 1'b0;
      shift_op_out <= '0;
      simm24_out   <= '0;
      dest_out     <= '0;
      src1_out     <= '0;
      src2_out     <= '0;
    end else if (!freeze) begin
      pc_out       <= pc_in;
      valid_out    <= !bubble;
      ctrl_q       <= bubble ? CTRL_NONE : ctrl;
      val_rn_out   <= rn_val;
      val_rm_out   <= rm_val;
      imm_out      <= imm_bit;
      shift_op_out <= instr_in[11:0];
      simm24_out   <= instr_in[23:0];
      dest_out     <= rd[REG_W-1:0];
      src1_out     <= rn[REG_W-1:0];
      src2_out     <= src2_sel[REG_W-1:0];
    end
  end

  assign s_out        = ctrl_q.s;
  assign b_out        = ctrl_q.b;
  assign mem_r_en_out = ctrl_q.mem_r;
  assign mem_w_en_out = ctrl_q.mem_w;
  assign wb_en_out    = ctrl_q.wb_en;
  assign exe_cmd_out  = ctrl_q.exe_cmd;

endmodule
